// File: rtl/duck_round_ctl.sv
// Round/wave scheduler for the duck motion controller.
// It launches ducks with pseudo-random start position, direction and reflection budget,
// scales speeds with the round number, and keeps per-round hit/miss tallies.
module duck_round_ctl #(
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned PASS_HITS       = 6,
  parameter int unsigned MAX_ROUND       = 15,
  parameter int unsigned TIMEOUT_FRAMES  = 600,
  parameter int unsigned HIT_FRAMES      = 30,
  parameter int unsigned GAP_FRAMES      = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       new_frame_i,
  input  logic       game_start_i,
  input  logic       shot_hit_i,
  input  logic       duck_escaped_i,
  output logic       duck_run_o,
  output logic       duck_falling_o,
  output logic       duck_direction_o,
  output logic [4:0] reflections_o,
  output logic [4:0] duck_v_spd_o,
  output logic [4:0] duck_h_spd_o,
  output logic [9:0] duck_start_x_o,
  output logic [3:0] round_num_o,
  output logic [3:0] duck_idx_o,
  output logic [3:0] hit_count_o,
  output logic [3:0] miss_count_o,
  output logic       round_done_o,
  output logic       game_over_o
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StLoad     = 3'd1;
  localparam logic [2:0] StFly      = 3'd2;
  localparam logic [2:0] StHit      = 3'd3;
  localparam logic [2:0] StEscape   = 3'd4;
  localparam logic [2:0] StGap      = 3'd5;
  localparam logic [2:0] StRoundEnd = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  hits_q, hits_d;
  logic [3:0]  miss_q, miss_d;
  logic        run_q, run_d;
  logic        falling_q, falling_d;
  logic        dir_q, dir_d;
  logic [4:0]  refl_q, refl_d;
  logic [4:0]  v_spd_q, v_spd_d;
  logic [4:0]  h_spd_q, h_spd_d;
  logic [9:0]  start_x_q, start_x_d;
  logic        round_done_q, round_done_d;
  logic        game_over_q, game_over_d;

  logic [5:0]  h_sum, v_sum;
  logic [3:0]  idx_inc;
  logic        fly_timeout, hit_done, gap_done;

  // Free-running right-shift Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Frame-wait terminal conditions: true on the cycle that samples the last frame.
  always_comb begin
    fly_timeout = new_frame_i && (frame_cnt_q == 16'(TIMEOUT_FRAMES - 1));
    hit_done    = new_frame_i && (frame_cnt_q == 16'(HIT_FRAMES - 1));
    gap_done    = new_frame_i && (frame_cnt_q == 16'(GAP_FRAMES - 1));
    idx_inc     = idx_q + 4'd1;
    h_sum       = 6'd4 + {2'b00, round_q};
    v_sum       = 6'd3 + {2'b00, round_q} + {5'b00000, lfsr_q[12]};
  end

  // Main sequencer: state transitions, tallies and configuration latching.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    idx_d       = idx_q;
    hits_d      = hits_q;
    miss_d      = miss_q;
    dir_d       = dir_q;
    v_spd_d     = v_spd_q;
    h_spd_d     = h_spd_q;
    start_x_d   = start_x_q;
    game_over_d = game_over_q;

    case (state_q)
      StIdle: begin
        if (game_start_i) begin
          round_d     = 4'd0;
          idx_d       = 4'd0;
          hits_d      = 4'd0;
          miss_d      = 4'd0;
          game_over_d = 1'b0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        start_x_d = 10'd64 + {1'b0, lfsr_q[8:0]};
        dir_d     = lfsr_q[9];
        h_spd_d   = (h_sum > 6'd31) ? 5'd31 : h_sum[4:0];
        v_spd_d   = (v_sum > 6'd31) ? 5'd31 : v_sum[4:0];
        state_d   = StFly;
      end
      StFly: begin
        // A hit outranks an escape or timeout in the same cycle.
        if (shot_hit_i) begin
          hits_d  = hits_q + 4'd1;
          state_d = StHit;
        end else if (duck_escaped_i || fly_timeout) begin
          state_d = StEscape;
        end
      end
      StHit: begin
        if (hit_done) state_d = StGap;
      end
      StEscape: begin
        miss_d  = miss_q + 4'd1;
        state_d = StGap;
      end
      StGap: begin
        if (gap_done) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == 4'(DUCKS_PER_ROUND)) ? StRoundEnd : StLoad;
        end
      end
      StRoundEnd: begin
        if ((32'(hits_q) >= PASS_HITS) && (32'(round_q) < MAX_ROUND)) begin
          round_d = round_q + 4'd1;
          idx_d   = 4'd0;
          hits_d  = 4'd0;
          miss_d  = 4'd0;
          state_d = StLoad;
        end else begin
          game_over_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame counter restarts on every state change and counts frames in waiting states.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = 16'd0;
    end else if (new_frame_i && (state_q == StFly || state_q == StHit || state_q == StGap)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Registered status outputs decoded from the next state so they align with it.
  always_comb begin
    run_d        = (state_d == StFly);
    falling_d    = (state_d == StHit);
    round_done_d = (state_d == StRoundEnd);
    refl_d       = 5'd0;
    if (state_d == StFly) begin
      refl_d = (state_q == StLoad) ? (5'd3 + {3'b000, lfsr_q[11:10]}) : refl_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      lfsr_q       <= 16'hACE1;
      frame_cnt_q  <= 16'd0;
      round_q      <= 4'd0;
      idx_q        <= 4'd0;
      hits_q       <= 4'd0;
      miss_q       <= 4'd0;
      run_q        <= 1'b0;
      falling_q    <= 1'b0;
      dir_q        <= 1'b0;
      refl_q       <= 5'd0;
      v_spd_q      <= 5'd0;
      h_spd_q      <= 5'd0;
      start_x_q    <= 10'd0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      frame_cnt_q  <= frame_cnt_d;
      round_q      <= round_d;
      idx_q        <= idx_d;
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      run_q        <= run_d;
      falling_q    <= falling_d;
      dir_q        <= dir_d;
      refl_q       <= refl_d;
      v_spd_q      <= v_spd_d;
      h_spd_q      <= h_spd_d;
      start_x_q    <= start_x_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
    end
  end

  assign duck_run_o       = run_q;
  assign duck_falling_o   = falling_q;
  assign duck_direction_o = dir_q;
  assign reflections_o    = refl_q;
  assign duck_v_spd_o     = v_spd_q;
  assign duck_h_spd_o     = h_spd_q;
  assign duck_start_x_o   = start_x_q;
  assign round_num_o      = round_q;
  assign duck_idx_o       = idx_q;
  assign hit_count_o      = hits_q;
  assign miss_count_o     = miss_q;
  assign round_done_o     = round_done_q;
  assign game_over_o      = game_over_q;

endmodule

// File: tb/tb_duck_round_ctl.sv
// Self-checking bench for duck_round_ctl: scenario tasks with a config/tally scoreboard.
module tb_duck_round_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_frame = 1'b0;
  logic       game_start = 1'b0;
  logic       shot_hit = 1'b0;
  logic       duck_escaped = 1'b0;
  logic       duck_run, duck_falling, duck_direction, round_done, game_over;
  logic [4:0] reflections, duck_v_spd, duck_h_spd;
  logic [9:0] duck_start_x;
  logic [3:0] round_num, duck_idx, hit_count, miss_count;

  duck_round_ctl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .new_frame_i     (new_frame),
    .game_start_i    (game_start),
    .shot_hit_i      (shot_hit),
    .duck_escaped_i  (duck_escaped),
    .duck_run_o      (duck_run),
    .duck_falling_o  (duck_falling),
    .duck_direction_o(duck_direction),
    .reflections_o   (reflections),
    .duck_v_spd_o    (duck_v_spd),
    .duck_h_spd_o    (duck_h_spd),
    .duck_start_x_o  (duck_start_x),
    .round_num_o     (round_num),
    .duck_idx_o      (duck_idx),
    .hit_count_o     (hit_count),
    .miss_count_o    (miss_count),
    .round_done_o    (round_done),
    .game_over_o     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic       dir;
    logic [4:0] refl;
    logic [4:0] h;
    logic [4:0] v;
  } cfg_t;

  typedef struct packed {
    logic [3:0] hits;
    logic [3:0] miss;
  } cnt_t;

  cfg_t cfg_q[$];
  cnt_t cnt_q[$];

  int n_pass = 0;
  int n_total = 0;
  int rd_cnt = 0;
  int e_rd = 0;
  int e_round = 0;
  int e_idx = 0;
  int e_hits = 0;
  int e_miss = 0;

  // Reference LFSR: right-shift Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(negedge clk) if (rst_n && round_done) rd_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_frames(input int n);
    repeat (n) begin
      @(negedge clk); new_frame = 1'b1;
      @(negedge clk); new_frame = 1'b0;
    end
  endtask

  // Called at a negedge while the DUT sits in LOAD; checks the FLY cycle that follows.
  task automatic test_launch(input string tag);
    cfg_t        e, o;
    logic [15:0] l;
    int          hs, vs;
    l      = m_lfsr;
    e.x    = 10'd64 + {1'b0, l[8:0]};
    e.dir  = l[9];
    e.refl = 5'd3 + {3'b000, l[11:10]};
    hs = 4 + e_round;           if (hs > 31) hs = 31;
    vs = 3 + e_round + int'(l[12]); if (vs > 31) vs = 31;
    e.h = 5'(hs);
    e.v = 5'(vs);
    cfg_q.push_back(e);
    @(negedge clk);
    e = cfg_q.pop_front();
    o = {duck_start_x, duck_direction, reflections, duck_h_spd, duck_v_spd};
    n_total++;
    if (duck_run !== 1'b1) $display("FAIL %s launch_run: got %b want 1", tag, duck_run);
    else n_pass++;
    n_total++;
    if (o !== e) $display("FAIL %s launch_cfg: got %h want %h", tag, o, e);
    else n_pass++;
    n_total++;
    if (reflections < 5'd3 || reflections > 5'd6 || duck_start_x < 10'd64 ||
        duck_start_x > 10'd575)
      $display("FAIL %s launch_range: got refl %0d x %0d want 3..6 / 64..575", tag,
               reflections, duck_start_x);
    else n_pass++;
    n_total++;
    if (duck_idx !== 4'(e_idx) || round_num !== 4'(e_round))
      $display("FAIL %s launch_idx: got idx %0d round %0d want %0d %0d", tag, duck_idx,
               round_num, e_idx, e_round);
    else n_pass++;
  endtask

  // Finishes the GAP wait, then follows the round-end decision if the round is complete.
  task automatic end_gap(input string tag);
    pulse_frames(60);
    e_idx++;
    if (e_idx == 10) begin
      e_rd++;
      n_total++;
      if (round_done !== 1'b1) $display("FAIL %s round_done: got %b want 1", tag, round_done);
      else n_pass++;
      if (e_hits >= 6 && e_round < 15) begin
        e_round++; e_idx = 0; e_hits = 0; e_miss = 0;
        @(negedge clk);
        test_launch(tag);
      end else begin
        @(negedge clk);
        n_total++;
        if (game_over !== 1'b1 || duck_run !== 1'b0 || round_done !== 1'b0)
          $display("FAIL %s game_over: got go %b run %b rd %b want 1 0 0", tag, game_over,
                   duck_run, round_done);
        else n_pass++;
      end
      n_total++;
      if (rd_cnt !== e_rd) $display("FAIL %s round_done_count: got %0d want %0d", tag, rd_cnt,
                                    e_rd);
      else n_pass++;
    end else begin
      test_launch(tag);
    end
  endtask

  // Flies one duck from FLY: either shot or escaped, then waits out the gap.
  task automatic run_duck(input bit hit, input string tag);
    cnt_t c;
    pulse_frames(2);
    if (hit) begin
      @(negedge clk); new_frame = 1'b1; shot_hit = 1'b1;
      e_hits++;
      cnt_q.push_back({4'(e_hits), 4'(e_miss)});
      @(negedge clk); new_frame = 1'b0; shot_hit = 1'b0;
      c = cnt_q.pop_front();
      n_total++;
      if ({hit_count, miss_count} !== c || duck_falling !== 1'b1 || duck_run !== 1'b0)
        $display("FAIL %s hit: got cnt %h fall %b run %b want %h 1 0", tag,
                 {hit_count, miss_count}, duck_falling, duck_run, c);
      else n_pass++;
      pulse_frames(30);
    end else begin
      @(negedge clk); duck_escaped = 1'b1;
      @(negedge clk); duck_escaped = 1'b0;
      e_miss++;
      cnt_q.push_back({4'(e_hits), 4'(e_miss)});
      n_total++;
      if (duck_run !== 1'b0) $display("FAIL %s escape_run: got %b want 0", tag, duck_run);
      else n_pass++;
      @(negedge clk);
      c = cnt_q.pop_front();
      n_total++;
      if ({hit_count, miss_count} !== c)
        $display("FAIL %s miss: got cnt %h want %h", tag, {hit_count, miss_count}, c);
      else n_pass++;
    end
    end_gap(tag);
  endtask

  task automatic start_game(input string tag);
    @(negedge clk); game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    e_round = 0; e_idx = 0; e_hits = 0; e_miss = 0;
    n_total++;
    if (duck_run !== 1'b0 || game_over !== 1'b0)
      $display("FAIL %s load: got run %b go %b want 0 0", tag, duck_run, game_over);
    else n_pass++;
    test_launch(tag);
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({duck_run, duck_falling, round_done, game_over} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {duck_run, duck_falling, round_done,
                                                       game_over});
    else n_pass++;
    n_total++;
    if ({round_num, duck_idx, hit_count, miss_count} !== 16'h0)
      $display("FAIL reset_counters: got %h want 0000", {round_num, duck_idx, hit_count,
                                                           miss_count});
    else n_pass++;
    n_total++;
    if ({reflections, duck_v_spd, duck_h_spd, duck_start_x, duck_direction} !== 26'h0)
      $display("FAIL reset_cfg: got %h want 0", {reflections, duck_v_spd, duck_h_spd,
                                                   duck_start_x, duck_direction});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (duck_run !== 1'b0) $display("FAIL idle_hold: got %b want 0", duck_run);
    else n_pass++;
  endtask

  task automatic test_shot();
    cnt_t c;
    pulse_frames(4);
    @(negedge clk); new_frame = 1'b1; shot_hit = 1'b1;
    e_hits++;
    cnt_q.push_back({4'(e_hits), 4'(e_miss)});
    @(negedge clk); new_frame = 1'b0; shot_hit = 1'b0;
    c = cnt_q.pop_front();
    n_total++;
    if (duck_run !== 1'b0 || duck_falling !== 1'b1 || {hit_count, miss_count} !== c)
      $display("FAIL shot: got run %b fall %b cnt %h want 0 1 %h", duck_run, duck_falling,
               {hit_count, miss_count}, c);
    else n_pass++;
    pulse_frames(29);
    n_total++;
    if (duck_falling !== 1'b1 || reflections !== 5'd0)
      $display("FAIL hit_hold: got fall %b refl %0d want 1 0", duck_falling, reflections);
    else n_pass++;
    pulse_frames(1);
    n_total++;
    if (duck_falling !== 1'b0) $display("FAIL hit_end: got %b want 0", duck_falling);
    else n_pass++;
    pulse_frames(59);
    n_total++;
    if (duck_run !== 1'b0) $display("FAIL gap_hold: got %b want 0", duck_run);
    else n_pass++;
    pulse_frames(1);
    e_idx++;
    test_launch("shot_next");
  endtask

  task automatic test_timeout();
    cnt_t c;
    pulse_frames(599);
    n_total++;
    if (duck_run !== 1'b1) $display("FAIL timeout_early: got %b want 1", duck_run);
    else n_pass++;
    pulse_frames(1);
    n_total++;
    if (duck_run !== 1'b0) $display("FAIL timeout_run: got %b want 0", duck_run);
    else n_pass++;
    e_miss++;
    cnt_q.push_back({4'(e_hits), 4'(e_miss)});
    @(negedge clk);
    c = cnt_q.pop_front();
    n_total++;
    if ({hit_count, miss_count} !== c)
      $display("FAIL timeout_miss: got %h want %h", {hit_count, miss_count}, c);
    else n_pass++;
    end_gap("timeout");
  endtask

  task automatic test_both();
    cnt_t c;
    pulse_frames(2);
    @(negedge clk); shot_hit = 1'b1; duck_escaped = 1'b1;
    e_hits++;
    cnt_q.push_back({4'(e_hits), 4'(e_miss)});
    @(negedge clk); shot_hit = 1'b0; duck_escaped = 1'b0;
    c = cnt_q.pop_front();
    n_total++;
    if ({hit_count, miss_count} !== c || duck_falling !== 1'b1)
      $display("FAIL both: got cnt %h fall %b want %h 1", {hit_count, miss_count},
               duck_falling, c);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (miss_count !== 4'(e_miss)) $display("FAIL both_miss: got %0d want %0d", miss_count,
                                            e_miss);
    else n_pass++;
    pulse_frames(30);
    end_gap("both");
  endtask

  task automatic test_round_pass();
    for (int i = 0; i < 4; i++) run_duck(1'b1, "pass_hit");
    run_duck(1'b0, "pass_miss");
    run_duck(1'b0, "pass_last");
    n_total++;
    if (duck_h_spd !== 5'd5 || round_num !== 4'd1)
      $display("FAIL round1_speed: got h %0d round %0d want 5 1", duck_h_spd, round_num);
    else n_pass++;
  endtask

  task automatic test_round_fail();
    for (int i = 0; i < 5; i++) run_duck(1'b1, "fail_hit");
    for (int i = 0; i < 5; i++) run_duck(1'b0, "fail_miss");
    // Inputs other than game_start are ignored in IDLE.
    @(negedge clk); shot_hit = 1'b1; duck_escaped = 1'b1;
    @(negedge clk); shot_hit = 1'b0; duck_escaped = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (game_over !== 1'b1 || hit_count !== 4'd5 || miss_count !== 4'd5 || duck_run !== 1'b0)
      $display("FAIL idle_after_over: got go %b hits %0d miss %0d run %b want 1 5 5 0",
               game_over, hit_count, miss_count, duck_run);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flight();
    start_game("restart");
    pulse_frames(10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({duck_run, duck_falling, round_done, game_over, round_num, duck_idx, hit_count,
         miss_count, reflections, duck_v_spd, duck_h_spd, duck_start_x, duck_direction} !== '0)
      $display("FAIL async_reset: got run %b refl %0d x %0d want all 0", duck_run,
               reflections, duck_start_x);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    start_game("after_reset");
    run_duck(1'b1, "after_reset_duck");
  endtask

  initial begin
    test_reset();
    start_game("start");
    test_shot();
    test_timeout();
    run_duck(1'b0, "escape");
    test_both();
    test_round_pass();
    test_round_fail();
    test_reset_mid_flight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
